// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: merges ALU and load results onto the single register-file
// write port in acceptance order and flags destination registers still in flight.

module wb_queue #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [4:0]        push_reg,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic [4:0]        lookup_reg_1,
  input  logic [4:0]        lookup_reg_2,
  output logic              ready,
  output logic              nonempty,
  output logic [4:0]        head_reg,
  output logic [DATA_W-1:0] head_data,
  output logic              hit_1,
  output logic              hit_2
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    Q_EMPTY,
    Q_PARTIAL,
    Q_FULL
  } q_state_t;

  q_state_t          state;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [AW:0]       count;
  logic [AW:0]       count_nxt;
  logic [AW-1:0]     offs;
  logic [4:0]        reg_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + (AW+1)'(1);
    else if (pop && !push)
      count_nxt = count - (AW+1)'(1);
  end

  // Control state: pointers, occupancy and the derived EMPTY/PARTIAL/FULL state
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      state  <= Q_EMPTY;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      if (count_nxt == '0)
        state <= Q_EMPTY;
      else if (count_nxt == (AW+1)'(DEPTH))
        state <= Q_FULL;
      else
        state <= Q_PARTIAL;
    end
  end

  // Payload storage carries no reset; occupancy alone decides which slots are live
  always_ff @(posedge clk) begin
    if (push) begin
      reg_mem[wr_ptr]  <= push_reg;
      data_mem[wr_ptr] <= push_data;
    end
  end

  assign ready     = (state != Q_FULL);
  assign nonempty  = (state != Q_EMPTY);
  assign head_reg  = reg_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  // A slot is live when its distance from the read pointer is below the count
  always_comb begin
    hit_1 = 1'b0;
    hit_2 = 1'b0;
    offs  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs = AW'(i) - rd_ptr;
      if ({1'b0, offs} < count) begin
        if ((lookup_reg_1 != 5'd0) && (reg_mem[i] == lookup_reg_1))
          hit_1 = 1'b1;
        if ((lookup_reg_2 != 5'd0) && (reg_mem[i] == lookup_reg_2))
          hit_2 = 1'b1;
      end
    end
  end

endmodule

module regfile_wb_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_reg,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [4:0]  mem_reg,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data,
  output logic        regWrite,
  input  logic [4:0]  lookup_reg_1,
  input  logic [4:0]  lookup_reg_2,
  output logic        pending_1,
  output logic        pending_2,
  output logic        idle
);

  localparam int DATA_W = 32;
  localparam int OD     = 2 * DEPTH;
  localparam int OW     = $clog2(OD);

  logic              a_ready, m_ready;
  logic              a_nonempty, m_nonempty;
  logic [4:0]        a_head_reg, m_head_reg;
  logic [DATA_W-1:0] a_head_data, m_head_data;
  logic              a_hit_1, a_hit_2, m_hit_1, m_hit_2;
  logic              a_push, m_push, a_pop, m_pop, pop;
  logic [1:0]        n_push;
  logic              head_id;

  logic              ord_mem [OD];
  logic [OW-1:0]     ord_rd;
  logic [OW-1:0]     ord_wr;
  logic [OW-1:0]     ord_wr_1;
  logic [OW:0]       ord_cnt;

  logic [4:0]        sel_reg;
  logic [DATA_W-1:0] sel_data;

  assign alu_ready = !rst && a_ready;
  assign mem_ready = !rst && m_ready;
  assign a_push    = alu_valid && alu_ready;
  assign m_push    = mem_valid && mem_ready;
  assign n_push    = {1'b0, a_push} + {1'b0, m_push};

  // The order FIFO drains one entry per cycle whenever it holds anything
  assign pop     = !rst && (ord_cnt != '0);
  assign head_id = ord_mem[ord_rd];
  assign a_pop   = pop && !head_id;
  assign m_pop   = pop && head_id;

  wb_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_qa (
    .clk          (clk),
    .rst          (rst),
    .push         (a_push),
    .push_reg     (alu_reg),
    .push_data    (alu_data),
    .pop          (a_pop),
    .lookup_reg_1 (lookup_reg_1),
    .lookup_reg_2 (lookup_reg_2),
    .ready        (a_ready),
    .nonempty     (a_nonempty),
    .head_reg     (a_head_reg),
    .head_data    (a_head_data),
    .hit_1        (a_hit_1),
    .hit_2        (a_hit_2)
  );

  wb_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_qm (
    .clk          (clk),
    .rst          (rst),
    .push         (m_push),
    .push_reg     (mem_reg),
    .push_data    (mem_data),
    .pop          (m_pop),
    .lookup_reg_1 (lookup_reg_1),
    .lookup_reg_2 (lookup_reg_2),
    .ready        (m_ready),
    .nonempty     (m_nonempty),
    .head_reg     (m_head_reg),
    .head_data    (m_head_data),
    .hit_1        (m_hit_1),
    .hit_2        (m_hit_2)
  );

  assign ord_wr_1 = ord_wr + OW'(1);

  // Order FIFO control: up to two pushes and one pop per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      ord_rd  <= '0;
      ord_wr  <= '0;
      ord_cnt <= '0;
    end else begin
      ord_wr <= ord_wr + OW'(n_push);
      if (pop)
        ord_rd <= ord_rd + OW'(1);
      ord_cnt <= ord_cnt + (OW+1)'(n_push) - (OW+1)'(pop);
    end
  end

  // On a dual accept the ALU id lands first, so it is treated as the older write
  always_ff @(posedge clk) begin
    if (a_push)
      ord_mem[ord_wr] <= 1'b0;
    if (m_push)
      ord_mem[a_push ? ord_wr_1 : ord_wr] <= 1'b1;
  end

  assign sel_reg  = head_id ? m_head_reg  : a_head_reg;
  assign sel_data = head_id ? m_head_data : a_head_data;

  always_comb begin
    write_reg  = '0;
    write_data = '0;
    regWrite   = 1'b0;
    if (pop) begin
      write_reg  = sel_reg;
      write_data = sel_data;
      regWrite   = (sel_reg != 5'd0);
    end
  end

  assign pending_1 = !rst && (a_hit_1 || m_hit_1);
  assign pending_2 = !rst && (a_hit_2 || m_hit_2);
  assign idle      = rst || (!a_nonempty && !m_nonempty);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus randomized traffic checked
// every cycle against a single in-order queue model of outstanding writes.

module tb_regfile_wb_arbiter;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_reg = '0;
  logic [31:0] alu_data = '0;
  logic        alu_ready;
  logic        mem_valid = 1'b0;
  logic [4:0]  mem_reg = '0;
  logic [31:0] mem_data = '0;
  logic        mem_ready;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        regWrite;
  logic [4:0]  lookup_reg_1 = '0;
  logic [4:0]  lookup_reg_2 = '0;
  logic        pending_1, pending_2, idle;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_valid    (alu_valid),
    .alu_reg      (alu_reg),
    .alu_data     (alu_data),
    .alu_ready    (alu_ready),
    .mem_valid    (mem_valid),
    .mem_reg      (mem_reg),
    .mem_data     (mem_data),
    .mem_ready    (mem_ready),
    .write_reg    (write_reg),
    .write_data   (write_data),
    .regWrite     (regWrite),
    .lookup_reg_1 (lookup_reg_1),
    .lookup_reg_2 (lookup_reg_2),
    .pending_1    (pending_1),
    .pending_2    (pending_2),
    .idle         (idle)
  );

  typedef struct {
    logic        id;
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  typedef struct {
    int          c;
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  ent_t mq[$];
  wr_t  wlog[$];
  int   cnt_a = 0;
  int   cnt_m = 0;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: one queue of outstanding writes in acceptance order, plus per-source occupancy
  always @(negedge clk) begin : compare
    logic        ea, em, ewe, ep1, ep2, eidle;
    logic [4:0]  er;
    logic [31:0] ed;
    cyc++;
    ea = 1'b0; em = 1'b0; ewe = 1'b0; ep1 = 1'b0; ep2 = 1'b0;
    er = '0; ed = '0;
    eidle = rst || (mq.size() == 0);
    if (!rst) begin
      ea = (cnt_a < DEPTH);
      em = (cnt_m < DEPTH);
      if (mq.size() > 0) begin
        er  = mq[0].r;
        ed  = mq[0].d;
        ewe = (mq[0].r != 5'd0);
      end
      foreach (mq[i]) begin
        if (lookup_reg_1 != 5'd0 && mq[i].r == lookup_reg_1) ep1 = 1'b1;
        if (lookup_reg_2 != 5'd0 && mq[i].r == lookup_reg_2) ep2 = 1'b1;
      end
    end
    chk("alu_ready",  32'(alu_ready),  32'(ea));
    chk("mem_ready",  32'(mem_ready),  32'(em));
    chk("regWrite",   32'(regWrite),   32'(ewe));
    chk("write_reg",  32'(write_reg),  32'(er));
    chk("write_data", write_data,      ed);
    chk("pending_1",  32'(pending_1),  32'(ep1));
    chk("pending_2",  32'(pending_2),  32'(ep2));
    chk("idle",       32'(idle),       32'(eidle));
    if (!rst && regWrite)
      wlog.push_back(wr_t'{cyc, write_reg, write_data});
    if (rst) begin
      mq.delete();
      cnt_a = 0;
      cnt_m = 0;
    end else begin
      if (mq.size() > 0) begin
        if (mq[0].id) cnt_m--; else cnt_a--;
        void'(mq.pop_front());
      end
      if (alu_valid && ea) begin
        mq.push_back(ent_t'{1'b0, alu_reg, alu_data});
        cnt_a++;
      end
      if (mem_valid && em) begin
        mq.push_back(ent_t'{1'b1, mem_reg, mem_data});
        cnt_m++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int n_before;
    logic rdy;
    int tries;

    // Reset held: outputs forced
    ticks(2);
    chk("rst_alu_ready", 32'(alu_ready), 0);
    chk("rst_mem_ready", 32'(mem_ready), 0);
    chk("rst_idle",      32'(idle),      1);
    rst = 1'b0;
    #1;
    chk("post_rst_alu_ready", 32'(alu_ready), 1);
    chk("post_rst_regWrite",  32'(regWrite),  0);
    chk("post_rst_idle",      32'(idle),      1);

    // Single write
    alu_valid = 1'b1; alu_reg = 5'd8; alu_data = 32'h5; lookup_reg_1 = 5'd8;
    tick();
    alu_valid = 1'b0;
    chk("single_we",   32'(regWrite),  1);
    chk("single_reg",  32'(write_reg), 8);
    chk("single_data", write_data,     32'h5);
    chk("single_pend", 32'(pending_1), 1);
    tick();
    chk("single_idle", 32'(idle),      1);
    chk("single_done", 32'(regWrite),  0);

    // Simultaneous accept, same destination
    alu_valid = 1'b1; alu_reg = 5'd9; alu_data = 32'h11;
    mem_valid = 1'b1; mem_reg = 5'd9; mem_data = 32'h22; lookup_reg_1 = 5'd9;
    tick();
    alu_valid = 1'b0; mem_valid = 1'b0;
    chk("simul_first",  write_data,     32'h11);
    chk("simul_pend0",  32'(pending_1), 1);
    tick();
    chk("simul_second", write_data,     32'h22);
    chk("simul_reg",    32'(write_reg), 9);
    chk("simul_pend1",  32'(pending_1), 1);
    tick();
    chk("simul_pend2",  32'(pending_1), 0);
    chk("simul_done",   32'(regWrite),  0);

    // Memory stream 10..13 with ALU idle
    wlog.delete();
    for (int k = 0; k < 4; k++) begin
      mem_valid = 1'b1; mem_reg = 5'(10 + k); mem_data = 32'h100 + 32'(k);
      tries = 0;
      do begin
        rdy = mem_ready;
        tick();
        tries++;
      end while (!rdy && tries < 20);
      if (!rdy) begin
        tests++; fails++;
        $display("FAIL mem_stream_timeout: request %0d never accepted", k);
      end
    end
    mem_valid = 1'b0;
    ticks(4);
    chk("mstream_cnt", 32'(wlog.size()), 4);
    for (int i = 0; i < 4 && i < wlog.size(); i++)
      chk("mstream_reg", 32'(wlog[i].r), 32'(10 + i));

    // Both ports streaming: the load queue fills because only one write drains per cycle
    alu_valid = 1'b1; alu_reg = 5'd20; alu_data = 32'hA0;
    mem_valid = 1'b1; mem_reg = 5'd21; mem_data = 32'hB0;
    ticks(2);
    chk("full_mem_ready", 32'(mem_ready), 0);
    chk("full_alu_ready", 32'(alu_ready), 1);
    alu_valid = 1'b0; mem_valid = 1'b0;
    ticks(8);
    chk("full_drained", 32'(idle), 1);

    // Register zero consumes a cycle without writing
    wlog.delete();
    lookup_reg_1 = 5'd0; lookup_reg_2 = 5'd0;
    alu_valid = 1'b1; alu_reg = 5'd0; alu_data = 32'hDEAD;
    tick();
    alu_valid = 1'b0;
    chk("r0_we",    32'(regWrite),  0);
    chk("r0_data",  write_data,     32'hDEAD);
    chk("r0_pend",  32'(pending_1), 0);
    chk("r0_busy",  32'(idle),      0);
    tick();
    chk("r0_idle",  32'(idle),      1);
    chk("r0_nolog", 32'(wlog.size()), 0);

    // Interleave A, M, A
    wlog.delete();
    alu_valid = 1'b1; alu_reg = 5'd2; alu_data = 32'h2;
    tick();
    alu_valid = 1'b0; mem_valid = 1'b1; mem_reg = 5'd3; mem_data = 32'h3;
    tick();
    mem_valid = 1'b0; alu_valid = 1'b1; alu_reg = 5'd15; alu_data = 32'hF;
    tick();
    alu_valid = 1'b0;
    ticks(3);
    chk("il_cnt", 32'(wlog.size()), 3);
    if (wlog.size() == 3) begin
      chk("il_reg0", 32'(wlog[0].r), 2);
      chk("il_reg1", 32'(wlog[1].r), 3);
      chk("il_reg2", 32'(wlog[2].r), 15);
      chk("il_gap1", 32'(wlog[1].c - wlog[0].c), 1);
      chk("il_gap2", 32'(wlog[2].c - wlog[1].c), 1);
    end

    // Reset while both queues hold data
    alu_valid = 1'b1; alu_reg = 5'd4; alu_data = 32'hBAD0_0004;
    mem_valid = 1'b1; mem_reg = 5'd5; mem_data = 32'hBAD0_0005;
    lookup_reg_1 = 5'd5;
    ticks(4);
    rst = 1'b1;
    #1;
    chk("mrst_ready", 32'(alu_ready | mem_ready), 0);
    chk("mrst_we",    32'(regWrite),  0);
    chk("mrst_idle",  32'(idle),      1);
    chk("mrst_pend",  32'(pending_1), 0);
    tick();
    rst = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;
    #1;
    chk("arst_we",        32'(regWrite),  0);
    chk("arst_idle",      32'(idle),      1);
    chk("arst_alu_ready", 32'(alu_ready), 1);
    chk("arst_mem_ready", 32'(mem_ready), 1);
    n_before = wlog.size();
    ticks(3);
    chk("arst_nowrite", 32'(wlog.size()), 32'(n_before));

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 199) == 0);
      alu_valid    = ($urandom_range(0, 99) < 60);
      alu_reg      = 5'($urandom_range(0, 7));
      alu_data     = $urandom;
      mem_valid    = ($urandom_range(0, 99) < 55);
      mem_reg      = 5'($urandom_range(0, 7));
      mem_data     = $urandom;
      lookup_reg_1 = 5'($urandom_range(0, 7));
      lookup_reg_2 = 5'($urandom_range(0, 7));
      tick();
    end
    rst = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;
    ticks(10);
    chk("final_idle", 32'(idle), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
